data_memory: RTL and testbench

// - Word-addressed data RAM for the CPU datapath, sitting behind the ALU address path in the MEM stage.
// - Writes are synchronous and happen on the rising clock edge when Mem_Write=1.
// - Reads are combinational and gated by Mem_Read; the result feeds the write-back mux.
// - Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits. All words are zero after reset and at time zero.

---
 rtl/data_memory.sv | 84 ++++++++
 tb/tb_data_memory.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory
//   Word-addressed data RAM for the MEM stage. Writes happen on the rising
//   clock edge. Reads are combinational and return zero unless Mem_Read is
//   high. An asynchronous reset clears every word, and all words also start
//   at zero at time zero.
//
// Ports
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset; clears all words
//   Address     word address shared by read and write
//   Write_Data  word stored on a write
//   Mem_Write   write enable, sampled at posedge clk
//   Mem_Read    read enable, gates Read_Data combinationally
//   Read_Data   mem[Address] when Mem_Read && !rst, otherwise zero

// One storage word. Each word has its own reset branch, so a reset clears
// the whole array in parallel without a loop over a shared array.
module data_memory_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] q
);

    // The declaration initialiser sets the power-up value, so an unwritten
    // word reads zero even when rst is never pulsed.
    logic [DATA_WIDTH-1:0] q_r = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_r <= '0;
        else if (wr_en)
            q_r <= wr_data;
    end

    assign q = q_r;

endmodule

module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Mem_Write,
    input  logic                  Mem_Read,
    output logic [DATA_WIDTH-1:0] Read_Data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      wr_sel;

    // Decode the address into a one-hot write strobe. Only the selected
    // word can change, so neighbouring words are never disturbed.
    genvar w;
    generate
        for (w = 0; w < DEPTH; w++) begin : g_word
            assign wr_sel[w] = Mem_Write && (Address == ADDR_WIDTH'(w));

            data_memory_word #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_word (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (wr_sel[w]),
                .wr_data (Write_Data),
                .q       (mem[w])
            );
        end
    endgenerate

    // Zero-latency read. The path is also forced to zero during reset so
    // that no stale data escapes while the clear is in progress.
    assign Read_Data = (Mem_Read && !rst) ? mem[Address] : '0;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
//   Directed bench for data_memory, using hand-computed expected words.
//   Inputs change on the falling edge. Outputs are sampled 1 time unit
//   after an input change or after a rising edge.
module tb_data_memory;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [DW-1:0] Write_Data = '0;
    logic          Mem_Write = 1'b0;
    logic          Mem_Read = 1'b0;
    logic [DW-1:0] Read_Data;

    int checks = 0;
    int failures = 0;

    data_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Mem_Write  (Mem_Write),
        .Mem_Read   (Mem_Read),
        .Read_Data  (Read_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One write edge. Mem_Read is left as the caller set it.
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        Address    = a;
        Write_Data = d;
        Mem_Write  = 1'b1;
        @(posedge clk);
        #1;
        Mem_Write  = 1'b0;
    endtask

    // Combinational read with no clock edge involved.
    task automatic rd(input string tag, input logic [AW-1:0] a,
                      input logic [DW-1:0] exp);
        Address  = a;
        Mem_Read = 1'b1;
        #1;
        check(tag, Read_Data, exp);
    endtask

    initial begin
        // Power-up contents with rst never pulsed.
        #1;
        rd("powerup_0x10", 8'h10, 32'h0);
        rd("powerup_0xff", 8'hFF, 32'h0);

        // Write then read.
        Mem_Read = 1'b0;
        wr(8'h10, 32'hA5A5A5A5);
        rd("wr_rd_0x10", 8'h10, 32'hA5A5A5A5);
        rd("unwritten_0x11", 8'h11, 32'h0);

        // Neighbour isolation.
        wr(8'h11, 32'h5A5A5A5A);
        rd("nbr_0x11", 8'h11, 32'h5A5A5A5A);
        rd("nbr_0x10", 8'h10, 32'hA5A5A5A5);

        // Read gating: low output, then the same timestep after Mem_Read rises.
        Address  = 8'h11;
        Mem_Read = 1'b0;
        #1;
        check("gate_off", Read_Data, 32'h0);
        Mem_Read = 1'b1;
        #0;
        #0;
        check("gate_on_same_ts", Read_Data, 32'h5A5A5A5A);

        // Read and write in the same cycle: the old word shows before the
        // edge and the new word shows after it.
        @(negedge clk);
        Address    = 8'h20;
        Write_Data = 32'h1234ABCD;
        Mem_Write  = 1'b1;
        Mem_Read   = 1'b1;
        #1;
        check("rw_before_edge", Read_Data, 32'h0);
        @(posedge clk);
        #1;
        Mem_Write = 1'b0;
        check("rw_after_edge", Read_Data, 32'h1234ABCD);

        // Boundary addresses.
        wr(8'h00, 32'hFFFFFFFF);
        wr(8'hFF, 32'h80000001);
        rd("addr_min", 8'h00, 32'hFFFFFFFF);
        rd("addr_max", 8'hFF, 32'h80000001);
        rd("addr_fe", 8'hFE, 32'h0);

        // Overwrite with zero.
        wr(8'h10, 32'h00000000);
        rd("ovw_0x10", 8'h10, 32'h0);
        rd("ovw_0x11", 8'h11, 32'h5A5A5A5A);

        // Asynchronous reset pulse between edges, with a write held during it.
        @(negedge clk);
        Address = 8'h11;
        #1;
        check("pre_rst_0x11", Read_Data, 32'h5A5A5A5A);
        rst = 1'b1;
        #1;
        check("rst_async_out", Read_Data, 32'h0);
        Address    = 8'h30;
        Write_Data = 32'hDEADBEEF;
        Mem_Write  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rd_gated", Read_Data, 32'h0);
        @(negedge clk);
        Mem_Write = 1'b0;
        rst       = 1'b0;
        rd("post_rst_0x30", 8'h30, 32'h0);
        rd("post_rst_0x10", 8'h10, 32'h0);
        rd("post_rst_0x11", 8'h11, 32'h0);
        rd("post_rst_0x20", 8'h20, 32'h0);
        rd("post_rst_0xff", 8'hFF, 32'h0);

        // First write after reset release takes effect at the next edge.
        wr(8'h40, 32'hC0FFEE00);
        rd("post_rst_wr", 8'h40, 32'hC0FFEE00);

        // Both enables low leaves the memory unchanged and the output at zero.
        @(negedge clk);
        Address    = 8'h40;
        Write_Data = 32'h11111111;
        Mem_Read   = 1'b0;
        @(posedge clk);
        #1;
        check("idle_out", Read_Data, 32'h0);
        rd("idle_keep", 8'h40, 32'hC0FFEE00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
